ten_eth_tx: RTL

Store-and-forward transmit buffer between the crossbar egress and the 10G Ethernet MAC TX AXI-Stream port. Each port has one instance. It does the following:
- Accepts packets from the crossbar, buffers them in full, and discards malformed or oversized ones by rewinding the write pointer.
- Replays only complete packets to the MAC, honouring MAC backpressure and a minimum inter-packet gap.
- Is the transmit counterpart of the per-port 10G receive path.

---
 rtl/ten_eth_tx.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/ten_eth_tx.sv
// ten_eth_tx: store-and-forward transmit buffer, crossbar egress -> 10G MAC TX AXI-Stream.
// Latency: first MAC beat 3 cycles after the input tlast (FSM idle, link up, gap expired).
// Backpressure: s_axis_tready low on full data buffer or descriptor queue; MAC tready holds the output register.
// Build option: define TEN_ETH_TX_ERR_DROP_EN to drop packets whose tlast beat carries s_axis_tuser=1.
module ten_eth_tx #(
    parameter int P_TX_ID      = 0,
    parameter int P_DEPTH_LOG2 = 8,
    parameter int P_MAX_BEATS  = 190,
    parameter int P_PKT_LOG2   = 4,
    parameter int P_GAP_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stat_tx_status,
    input  logic        s_axis_tvalid,
    input  logic [63:0] s_axis_tdata,
    input  logic        s_axis_tlast,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tuser,
    output logic        s_axis_tready,
    output logic        m_axis_tx_tvalid,
    output logic [63:0] m_axis_tx_tdata,
    output logic        m_axis_tx_tlast,
    output logic [7:0]  m_axis_tx_tkeep,
    output logic        m_axis_tx_tuser,
    input  logic        m_axis_tx_tready,
    output logic [31:0] o_tx_pkt_cnt,
    output logic [15:0] o_drop_cnt
);
    localparam int AW     = P_DEPTH_LOG2;
    localparam int PW     = P_DEPTH_LOG2 + 1;
    localparam int DEPTH  = 1 << P_DEPTH_LOG2;
    localparam int BW     = $clog2(P_MAX_BEATS + 1);
    localparam int QW     = P_PKT_LOG2;
    localparam int QDEPTH = 1 << P_PKT_LOG2;
    // GAP state covers all but the last idle cycle; the LOAD cycle supplies that one.
    localparam logic [15:0] GAP_LAST = 16'(P_GAP_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;

    // The port index is informational only; a negative value is simply meaningless.
    if (P_TX_ID < 0) begin : g_bad_tx_id
    end

    // Storage: beat buffer {tkeep, tdata} and per-packet beat-count descriptors
    logic [71:0]    r_mem  [DEPTH];
    logic [BW-1:0]  r_desc [QDEPTH];

    // Write side state
    logic [PW-1:0]  r_wr_ptr, r_cmt_ptr;
    logic [BW-1:0]  r_wr_beats;
    logic           r_dropping;
    logic [15:0]    r_drop_cnt;
    logic [QW:0]    r_dq_wr;
    logic           r_rdy_en;

    // Read side state
    state_t         r_state, w_state_nxt;
    logic [PW-1:0]  r_rd_ptr;
    logic [QW:0]    r_dq_rd;
    logic [BW-1:0]  r_rd_beats, r_fetch_left;
    logic [15:0]    r_gap_cnt;
    logic           r_out_vld;
    logic [71:0]    r_out_word;
    logic [31:0]    r_pkt_cnt;

    logic [PW-1:0]  w_used;
    logic [QW:0]    w_dq_used;
    logic           w_dq_full, w_dq_empty;
    logic           w_s_acc, w_err, w_drop, w_mem_we, w_push;
    logic           w_avail, w_out_acc, w_last_acc, w_load;
    logic [BW-1:0]  w_dq_cnt;

    assign w_used     = r_wr_ptr - r_rd_ptr;
    assign w_dq_used  = r_dq_wr - r_dq_rd;
    assign w_dq_full  = w_dq_used[QW];
    assign w_dq_empty = (r_dq_wr == r_dq_rd);
    assign w_dq_cnt   = r_desc[r_dq_rd[QW-1:0]];

    // Wrap bit set in the occupancy means exactly DEPTH beats are held
    assign s_axis_tready = r_rdy_en && !w_used[AW] && !w_dq_full;
    assign w_s_acc       = s_axis_tvalid && s_axis_tready;

`ifdef TEN_ETH_TX_ERR_DROP_EN
    assign w_err = s_axis_tuser;
`else
    // tuser is ignored in this build: errored packets are forwarded unchanged
    assign w_err = s_axis_tuser & 1'b0;
`endif

    // Classify each accepted beat: store, commit (tlast), or drop (oversize / error)
    always_comb begin
        w_drop   = 1'b0;
        w_mem_we = 1'b0;
        w_push   = 1'b0;
        if (w_s_acc && !r_dropping) begin
            if (r_wr_beats >= BW'(P_MAX_BEATS)) begin
                w_drop = 1'b1;
            end else if (s_axis_tlast && w_err) begin
                w_drop = 1'b1;
            end else begin
                w_mem_we = 1'b1;
                w_push   = s_axis_tlast;
            end
        end
    end

    // Beat buffer write port
    always_ff @(posedge i_clk) begin
        if (w_mem_we) r_mem[r_wr_ptr[AW-1:0]] <= {s_axis_tkeep, s_axis_tdata};
    end

    // Descriptor queue write port
    always_ff @(posedge i_clk) begin
        if (w_push) r_desc[r_dq_wr[QW-1:0]] <= r_wr_beats + BW'(1);
    end

    // Write pointers, commit/rewind, drop accounting
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_cmt_ptr  <= '0;
            r_wr_beats <= '0;
            r_dropping <= 1'b0;
            r_drop_cnt <= '0;
            r_dq_wr    <= '0;
            r_rdy_en   <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_mem_we) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
                if (s_axis_tlast) begin
                    r_cmt_ptr  <= r_wr_ptr + PW'(1);
                    r_wr_beats <= '0;
                end else begin
                    r_wr_beats <= r_wr_beats + BW'(1);
                end
            end
            if (w_drop) begin
                // Rewind; the rest of an oversize packet is swallowed without storing
                r_wr_ptr   <= r_cmt_ptr;
                r_wr_beats <= '0;
                r_dropping <= !s_axis_tlast;
                if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            if (w_s_acc && r_dropping && s_axis_tlast) r_dropping <= 1'b0;
            if (w_push) r_dq_wr <= r_dq_wr + (QW+1)'(1);
        end
    end

    assign w_avail    = !w_dq_empty && i_stat_tx_status;
    assign w_out_acc  = r_out_vld && m_axis_tx_tready;
    assign w_last_acc = w_out_acc && (r_rd_beats == BW'(1));

    // Read FSM next state; w_load pops a descriptor and fetches its first beat
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: if (w_avail) w_state_nxt = S_LOAD;
            S_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (w_last_acc) begin
                    if (P_GAP_CYCLES == 0) begin
                        // No gap: chain straight into the next packet
                        if (w_avail) w_load = 1'b1;
                        else         w_state_nxt = S_IDLE;
                    end else if (P_GAP_CYCLES == 1) begin
                        w_state_nxt = w_avail ? S_LOAD : S_IDLE;
                    end else begin
                        w_state_nxt = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) w_state_nxt = w_avail ? S_LOAD : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Read FSM state, buffer fetch into the output register, sent-packet counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_rd_ptr     <= '0;
            r_dq_rd      <= '0;
            r_rd_beats   <= '0;
            r_fetch_left <= '0;
            r_gap_cnt    <= '0;
            r_out_vld    <= 1'b0;
            r_out_word   <= '0;
            r_pkt_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == S_GAP && r_state != S_GAP) r_gap_cnt <= 16'd1;
            else if (r_state == S_GAP)                    r_gap_cnt <= r_gap_cnt + 16'd1;
            if (w_last_acc) r_pkt_cnt <= r_pkt_cnt + 32'd1;
            if (w_load) begin
                r_out_word   <= r_mem[r_rd_ptr[AW-1:0]];
                r_out_vld    <= 1'b1;
                r_rd_ptr     <= r_rd_ptr + PW'(1);
                r_rd_beats   <= w_dq_cnt;
                r_fetch_left <= w_dq_cnt - BW'(1);
                r_dq_rd      <= r_dq_rd + (QW+1)'(1);
            end else if (w_out_acc) begin
                r_rd_beats <= r_rd_beats - BW'(1);
                if (r_fetch_left != '0) begin
                    // Refill on the accept cycle so beats stay back-to-back
                    r_out_word   <= r_mem[r_rd_ptr[AW-1:0]];
                    r_rd_ptr     <= r_rd_ptr + PW'(1);
                    r_fetch_left <= r_fetch_left - BW'(1);
                end else begin
                    r_out_vld <= 1'b0;
                end
            end
        end
    end

    assign m_axis_tx_tvalid = r_out_vld;
    assign m_axis_tx_tdata  = r_out_word[63:0];
    assign m_axis_tx_tkeep  = r_out_word[71:64];
    assign m_axis_tx_tlast  = r_out_vld && (r_rd_beats == BW'(1));
    assign m_axis_tx_tuser  = 1'b0;
    assign o_tx_pkt_cnt     = r_pkt_cnt;
    assign o_drop_cnt       = r_drop_cnt;

endmodule
